aes_job_arbiter: RTL and testbench

Shares one AES-128 decryption core (io_ready start, aes_ready done, active-low core reset) among N requesters. Round-robin arbitration picks one job, then latches that job's ciphertext and key. The block then sequences the core: reset pulse, key-expansion settle, start strobe, wait for done with timeout. It returns the plaintext to the granted requester with a one-cycle ack. It sits between the host-side request ports and the decryption core.

---
 rtl/aes_arb_pkg.sv | 27 ++
 rtl/aes_job_arbiter_rr.sv | 43 ++++
 rtl/aes_job_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_aes_job_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_arb_pkg.sv
// -----------------------------------------------------------------------------
// aes_arb_pkg
// Shared types and constants for the AES job arbiter slice.
//   - state_e : job sequencing states of aes_job_arbiter
//   - AES_W   : AES block / key width
//   - idx_w() : index width for an n-entry selector (never below 1 bit)
// -----------------------------------------------------------------------------
package aes_arb_pkg;

  localparam int AES_W = 128;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SETTLE = 3'd2,
    START  = 3'd3,
    RUN    = 3'd4,
    DONE   = 3'd5
  } state_e;

  // ceil(log2(n)), but at least 1 so that a 1- or 2-entry index still has a bit
  function automatic int idx_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/aes_job_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Searches req starting at pointer+1 and
// wrapping around; pointer itself is checked last.
// Ports:
//   req     [N-1:0]  request vector
//   pointer [IW-1:0] index of the most recently served requester
//   gnt     [IW-1:0] index of the winning requester (0 when any_req is low)
//   any_req          at least one request bit set
// -----------------------------------------------------------------------------
module rr_arbiter
  import aes_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [IW-1:0] gnt,
  output logic          any_req
);

  // one extra bit so pointer+offset (at most 2N-1) never overflows before wrap
  logic [IW:0] sum;

  always_comb begin
    gnt     = '0;
    any_req = |req;
    sum     = '0;
    // Walk offsets from farthest to nearest; the last hit (smallest offset
    // from pointer+1) overwrites earlier ones and therefore wins.
    for (int off = N; off >= 1; off--) begin
      sum = {1'b0, pointer} + (IW+1)'(off);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      if (req[sum[IW-1:0]]) begin
        gnt = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/aes_job_arbiter.sv
// -----------------------------------------------------------------------------
// aes_job_arbiter
// Shares one AES-128 decryption core among N requesters. A round-robin pick
// latches the winner's ciphertext and key, then the core is sequenced:
// reset pulse, key settle, start strobe, wait for done (with timeout). The
// plaintext (or an error) is returned to the winner with a one-cycle ack.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req/req_msg/req_key        host side: level requests, packed 128-bit lanes
//   ack/resp_data/resp_id/
//   resp_err/busy              host side responses (all registered)
//   core_reset_n/core_msg_en/
//   core_key/core_io_ready     drive the decryption core (registered)
//   core_aes_ready/core_msg_de core done level and plaintext
// -----------------------------------------------------------------------------
module aes_job_arbiter
  import aes_arb_pkg::*;
#(
  parameter  int N          = 4,
  parameter  int KEY_SETTLE = 12,
  parameter  int TIMEOUT    = 255,
  localparam int IW         = idx_w(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*AES_W-1:0]   req_msg,
  input  logic [N*AES_W-1:0]   req_key,
  output logic [N-1:0]         ack,
  output logic [AES_W-1:0]     resp_data,
  output logic [IW-1:0]        resp_id,
  output logic                 resp_err,
  output logic                 busy,
  output logic                 core_reset_n,
  output logic [AES_W-1:0]     core_msg_en,
  output logic [AES_W-1:0]     core_key,
  output logic                 core_io_ready,
  input  logic                 core_aes_ready,
  input  logic [AES_W-1:0]     core_msg_de
);

  localparam int SW = idx_w(KEY_SETTLE + 1);
  localparam int TW = idx_w(TIMEOUT + 1);

  // unpacked views of the packed request lanes
  logic [AES_W-1:0] msg_lane [N];
  logic [AES_W-1:0] key_lane [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign msg_lane[gi] = req_msg[gi*AES_W +: AES_W];
    assign key_lane[gi] = req_key[gi*AES_W +: AES_W];
  end

  state_e           state_q, state_d;
  logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [IW-1:0]    gnt_id_q, gnt_id_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [AES_W-1:0] msg_q, msg_d;
  logic [AES_W-1:0] key_q, key_d;
  logic [AES_W-1:0] resp_data_q, resp_data_d;
  logic [IW-1:0]    resp_id_q, resp_id_d;
  logic             resp_err_q, resp_err_d;
  logic [N-1:0]     ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             core_reset_n_q, core_reset_n_d;
  logic             io_ready_q, io_ready_d;

  logic [IW-1:0]    arb_gnt;
  logic             arb_any;

  rr_arbiter #(.N(N)) u_rr (
    .req     (req),
    .pointer (ptr_q),
    .gnt     (arb_gnt),
    .any_req (arb_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      settle_cnt_q   <= '0;
      tmo_cnt_q      <= '0;
      gnt_id_q       <= '0;
      ptr_q          <= IW'(N - 1);   // requester 0 wins first
      msg_q          <= '0;
      key_q          <= '0;
      resp_data_q    <= '0;
      resp_id_q      <= '0;
      resp_err_q     <= 1'b0;
      ack_q          <= '0;
      busy_q         <= 1'b0;
      core_reset_n_q <= 1'b0;
      io_ready_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      settle_cnt_q   <= settle_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      gnt_id_q       <= gnt_id_d;
      ptr_q          <= ptr_d;
      msg_q          <= msg_d;
      key_q          <= key_d;
      resp_data_q    <= resp_data_d;
      resp_id_q      <= resp_id_d;
      resp_err_q     <= resp_err_d;
      ack_q          <= ack_d;
      busy_q         <= busy_d;
      core_reset_n_q <= core_reset_n_d;
      io_ready_q     <= io_ready_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    gnt_id_d     = gnt_id_q;
    ptr_d        = ptr_q;
    msg_d        = msg_q;
    key_d        = key_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_id_d = arb_gnt;
          msg_d    = msg_lane[arb_gnt];
          key_d    = key_lane[arb_gnt];
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        settle_cnt_d = '0;
        state_d      = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt_q == SW'(KEY_SETTLE - 1)) begin
          state_d = START;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      START: begin
        tmo_cnt_d = '0;
        state_d   = RUN;
      end
      RUN: begin
        // ready is checked first so a tie with the timeout counts as success
        if (core_aes_ready) begin
          resp_data_d = core_msg_de;
          resp_err_d  = 1'b0;
          resp_id_d   = gnt_id_q;
          state_d     = DONE;
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          resp_id_d   = gnt_id_q;
          state_d     = DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      DONE: begin
        ptr_d   = gnt_id_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Moore outputs are decoded from the next state so that the registered
    // copy lines up with the state it belongs to.
    core_reset_n_d = (state_d == SETTLE) || (state_d == START) || (state_d == RUN);
    io_ready_d     = (state_d == START);
    busy_d         = (state_d != IDLE);
    ack_d          = '0;
    if (state_d == DONE) begin
      ack_d[gnt_id_q] = 1'b1;
    end
  end

  assign ack           = ack_q;
  assign resp_data     = resp_data_q;
  assign resp_id       = resp_id_q;
  assign resp_err      = resp_err_q;
  assign busy          = busy_q;
  assign core_reset_n  = core_reset_n_q;
  assign core_msg_en   = msg_q;
  assign core_key      = key_q;
  assign core_io_ready = io_ready_q;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// -----------------------------------------------------------------------------
// tb_aes_job_arbiter
// Self-checking bench for aes_job_arbiter with a behavioural stub core that
// asserts done a programmable number of cycles after the start strobe.
// -----------------------------------------------------------------------------
module tb_aes_job_arbiter;

  localparam int N   = 4;
  localparam int KS  = 12;
  localparam int TMO = 255;

  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*128-1:0] req_msg;
  logic [N*128-1:0] req_key;
  logic [N-1:0]     ack;
  logic [127:0]     resp_data;
  logic [1:0]       resp_id;
  logic             resp_err;
  logic             busy;
  logic             core_reset_n;
  logic [127:0]     core_msg_en;
  logic [127:0]     core_key;
  logic             core_io_ready;
  logic             core_aes_ready;
  logic [127:0]     core_msg_de;

  int   checks   = 0;
  int   failures = 0;
  int   last_gnt = N - 1;
  int   job_no   = 0;
  int   core_lat = 20;
  logic stub_run = 1'b0;
  int   stub_cnt = 0;

  always #5 clk = ~clk;

  aes_job_arbiter #(.N(N), .KEY_SETTLE(KS), .TIMEOUT(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_msg        (req_msg),
    .req_key        (req_key),
    .ack            (ack),
    .resp_data      (resp_data),
    .resp_id        (resp_id),
    .resp_err       (resp_err),
    .busy           (busy),
    .core_reset_n   (core_reset_n),
    .core_msg_en    (core_msg_en),
    .core_key       (core_key),
    .core_io_ready  (core_io_ready),
    .core_aes_ready (core_aes_ready),
    .core_msg_de    (core_msg_de)
  );

  // stub core plaintext: the FIPS-197 vector decrypts correctly, anything
  // else gets an easily predicted mix of message and key
  function automatic logic [127:0] stub_pt(input logic [127:0] m, input logic [127:0] k);
    if (m == FIPS_CT && k == FIPS_KEY) return FIPS_PT;
    return m ^ {k[63:0], k[127:64]};
  endfunction

  // stub core: done goes high core_lat cycles after the start strobe,
  // stays high until the core is reset; core_lat==0 means never
  always @(posedge clk) begin
    if (!core_reset_n) begin
      stub_run <= 1'b0;
      stub_cnt <= 0;
    end else if (core_io_ready) begin
      stub_run <= 1'b1;
      stub_cnt <= 1;
    end else if (stub_run) begin
      stub_cnt <= stub_cnt + 1;
    end
  end
  assign core_aes_ready = stub_run && (core_lat != 0) && (stub_cnt >= core_lat);
  assign core_msg_de    = stub_pt(core_msg_en, core_key);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference round-robin rule: first set request after the last served one
  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic scramble_lanes();
    for (int j = 0; j < N * 4; j++) begin
      req_msg[j*32 +: 32] = $urandom();
      req_key[j*32 +: 32] = $urandom();
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_ack"},          128'(ack),           128'(0));
    chk({pfx, "_resp_data"},    resp_data,           128'(0));
    chk({pfx, "_resp_id"},      128'(resp_id),       128'(0));
    chk({pfx, "_resp_err"},     128'(resp_err),      128'(0));
    chk({pfx, "_busy"},         128'(busy),          128'(0));
    chk({pfx, "_io_ready"},     128'(core_io_ready), 128'(0));
    chk({pfx, "_core_reset_n"}, 128'(core_reset_n),  128'(0));
    chk({pfx, "_core_msg_en"},  core_msg_en,         128'(0));
    chk({pfx, "_core_key"},     core_key,            128'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    last_gnt = N - 1;
    @(negedge clk);
  endtask

  // Called at a negedge while the DUT is idle; that cycle is the request
  // cycle (cycle 0). Returns at the negedge of the idle cycle after the ack.
  task automatic run_one(input logic [N-1:0] req_now, input logic [N-1:0] req_after,
                         input int glitch_id);
    int           exp_id, runlen, c, io_pos, io_cnt, rst_low;
    logic [127:0] m, k, exp_data;
    logic         exp_err, got;
    logic [N-1:0] exp_ack;
    req     = req_now;
    exp_id  = pick(req_now, last_gnt);
    m       = req_msg[exp_id*128 +: 128];
    k       = req_key[exp_id*128 +: 128];
    exp_err = (core_lat == 0) || (core_lat > TMO);
    runlen  = exp_err ? TMO : core_lat;
    exp_data = exp_err ? 128'(0) : stub_pt(m, k);
    exp_ack = '0;
    exp_ack[exp_id] = 1'b1;
    got = 1'b0; io_pos = -1; io_cnt = 0; rst_low = 0;
    for (c = 1; c <= KS + TMO + 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("latched_msg", core_msg_en, m);
        chk("latched_key", core_key, k);
      end
      if (c == 3) scramble_lanes();
      if (glitch_id >= 0 && c == 4) req[glitch_id] = 1'b1;
      if (glitch_id >= 0 && c == 9) req[glitch_id] = 1'b0;
      if (|ack) begin
        got = 1'b1;
        break;
      end
      if (!core_reset_n) rst_low++;
      if (core_io_ready) begin
        io_cnt++;
        io_pos = c;
      end
    end
    chk("ack_seen",      128'(got),      128'(1));
    chk("ack_latency",   128'(c),        128'(3 + KS + runlen));
    chk("ack_onehot",    128'(ack),      128'(exp_ack));
    chk("resp_id",       128'(resp_id),  128'(exp_id));
    chk("resp_data",     resp_data,      exp_data);
    chk("resp_err",      128'(resp_err), 128'(exp_err));
    chk("io_ready_cnt",  128'(io_cnt),   128'(1));
    chk("io_ready_pos",  128'(io_pos),   128'(2 + KS));
    chk("core_rst_low",  128'(rst_low),  128'(1));
    $display("job %0d req=%b id=%0d lat=%0d cycles=%0d err=%0b data=%h",
             job_no, req_now, resp_id, core_lat, c, resp_err, resp_data);
    job_no++;
    last_gnt = exp_id;
    req = req_after;
    @(negedge clk);
    chk("busy_after_ack", 128'(busy),  128'(0));
    chk("ack_one_cycle",  128'(ack),   128'(0));
    chk("resp_hold",      resp_data,   exp_data);
  endtask

  initial begin
    int           order [5];
    logic [N-1:0] cur, nxt;
    logic         saw;
    order = '{0, 1, 2, 3, 0};

    reset = 1'b1;
    req   = '0;
    scramble_lanes();
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("post_rst");

    // known-answer job on requester 0, core latency 20
    req_msg[127:0] = FIPS_CT;
    req_key[127:0] = FIPS_KEY;
    core_lat = 20;
    run_one(4'b0001, 4'b0000, -1);

    // all requesters held: strict rotation starting at 0
    do_reset();
    for (int j = 0; j < 5; j++) begin
      core_lat = $urandom_range(1, 40);
      run_one(4'b1111, (j == 4) ? 4'b0000 : 4'b1111, -1);
      chk("rr_order", 128'(resp_id), 128'(order[j]));
    end

    // timeout, then a normal job
    core_lat = 0;
    run_one(4'b0100, 4'b0000, -1);
    core_lat = 7;
    run_one(4'b0010, 4'b0000, -1);

    // random request patterns and latencies, some chained back-to-back
    cur = 4'($urandom_range(1, 15));
    for (int j = 0; j < 8; j++) begin
      core_lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 30);
      nxt = (j == 7) ? 4'b0000 : 4'($urandom_range(0, 15));
      run_one(cur, nxt, -1);
      cur = (nxt != 4'b0000) ? nxt : 4'($urandom_range(1, 15));
    end

    // reset in RUN of requester 2: job abandoned, requester 0 first after
    core_lat = 0;
    req = 4'b0100;
    repeat (KS + 10) @(negedge clk);
    chk("run_busy",         128'(busy),         128'(1));
    chk("run_core_reset_n", 128'(core_reset_n), 128'(1));
    reset = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    req = 4'b0000;
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (|ack) saw = 1'b1;
    end
    chk("mid_rst_no_ack", 128'(saw), 128'(0));
    reset = 1'b0;
    last_gnt = N - 1;
    @(negedge clk);
    chk("rel_core_reset_n", 128'(core_reset_n), 128'(0));
    core_lat = $urandom_range(1, 30);
    run_one(4'b0101, 4'b0000, -1);

    // requester 1 pulses while requester 3 is being served: never acked
    core_lat = 15;
    run_one(4'b1000, 4'b0000, 1);
    saw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (|ack || busy) saw = 1'b1;
    end
    chk("withdrawn_not_served", 128'(saw), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
